// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Holds FSM states, next-PC select codes, PC increment and alignment mask.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        PEND = 2'b10
    } state_t;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_J    = 2'b10;
    localparam logic [1:0] PCSEL_PEND = 2'b11;

    localparam int PC_INC = 4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: picks pc+4, branch, jump or latched pending target.
// Ports: pc, branch_target, jump_target, pend_pc, pc_sel in; next_pc out.
module pc_next_sel
    import mips_pc_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jump_target,
    input  logic [PC_W-1:0] pend_pc,
    input  logic [1:0]      pc_sel,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] mask;

    assign mask = PC_W'(ALIGN_MASK);

    // pend_pc is already aligned when it was captured through this mux
    always_comb begin
        next_pc = pc + PC_W'(PC_INC);
        unique case (pc_sel)
            PCSEL_BR:   next_pc = branch_target & mask;
            PCSEL_J:    next_pc = jump_target & mask;
            PCSEL_PEND: next_pc = pend_pc;
            default:    next_pc = pc + PC_W'(PC_INC);
        endcase
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch-stage sequencer: owns PC, issues fetches, resolves redirects/stalls.
// Ports: clk, rst_n, stall, imem_ready, branch_taken/target, jump/target in;
//        pc, fetch_valid, pc_sel, flush_ifid, redirect_pending out.
// Build option: DELAY_SLOT_EN makes the branch delay slot architectural.
module pc_seq_ctrl
    import mips_pc_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic [1:0]      pc_sel,
    output logic            flush_ifid,
    output logic            redirect_pending
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pend_pc;
    logic [PC_W-1:0] next_pc;
    logic            pc_load;
    logic            pend_load;
    logic            fv;
    logic            redir;

    pc_next_sel #(
        .PC_W(PC_W)
    ) u_next (
        .pc           (pc),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .pend_pc      (pend_pc),
        .pc_sel       (pc_sel),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state <= state_nxt;
            if (pc_load)
                pc <= next_pc;
            if (pend_load)
                pend_pc <= next_pc;
        end
    end

    always_comb begin
        state_nxt  = state;
        fv         = 1'b0;
        flush_ifid = 1'b0;
        pc_sel     = PCSEL_SEQ;
        pc_load    = 1'b0;
        pend_load  = 1'b0;
        redir      = branch_taken | jump;
        unique case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                fv = !stall;
                if (redir) begin
                    // branch is from the older instruction: it wins
                    pc_sel = branch_taken ? PCSEL_BR : PCSEL_J;
`ifdef DELAY_SLOT_EN
                    // the fetch at pc is the delay slot; redirect only
                    // once it has been accepted
                    if (fv && imem_ready) begin
                        pc_load = 1'b1;
                    end else begin
                        pend_load = 1'b1;
                        state_nxt = PEND;
                    end
`else
                    // redirect overrides stall: stalled instr is squashed
                    flush_ifid = 1'b1;
                    if (imem_ready) begin
                        pc_load = 1'b1;
                    end else begin
                        pend_load = 1'b1;
                        state_nxt = PEND;
                    end
`endif
                end else if (fv && imem_ready) begin
                    pc_load = 1'b1;
                end
            end
            PEND: begin
                fv = 1'b1;
                // jump here is on the wrong path; only branch can replace
                pc_sel = branch_taken ? PCSEL_BR : PCSEL_PEND;
`ifndef DELAY_SLOT_EN
                flush_ifid = branch_taken;
`endif
                if (imem_ready) begin
                    pc_load   = 1'b1;
                    state_nxt = RUN;
                end else if (branch_taken) begin
                    pend_load = 1'b1;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign fetch_valid      = fv;
    assign redirect_pending = (state == PEND);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Testbench for pc_seq_ctrl: directed steps then randomized traffic,
// each cycle checked against a behavioural model of the fetch rules.
module tb_pc_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [1:0]  pc_sel;
    logic        flush_ifid;
    logic        redirect_pending;

    int total = 0;
    int bad   = 0;

    // model: booting flag, architectural pc, pending redirect
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_pending;
    logic [31:0] m_pend_pc;

    pc_seq_ctrl #(
        .PC_W    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .imem_ready      (imem_ready),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .pc              (pc),
        .fetch_valid     (fetch_valid),
        .pc_sel          (pc_sel),
        .flush_ifid      (flush_ifid),
        .redirect_pending(redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot    = 1'b1;
        m_pc      = 32'h0;
        m_pending = 1'b0;
        m_pend_pc = 32'h0;
    endtask

    // one clock of stimulus: starts and ends #1 after a rising edge
    task automatic step(input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic st, input logic rdy);
        logic        e_fv;
        logic        e_fl;
        logic [1:0]  e_sel;
        logic [31:0] tgt;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        stall         = st;
        imem_ready    = rdy;
        #1;
        tgt = (br ? bt : jt) & 32'hFFFF_FFFC;
        if (m_boot) begin
            e_fv  = 1'b0;
            e_fl  = 1'b0;
            e_sel = 2'b00;
        end else if (m_pending) begin
            e_fv  = 1'b1;
            e_fl  = br;
            e_sel = br ? 2'b01 : 2'b11;
        end else begin
            e_fv  = !st;
            e_fl  = br | j;
            e_sel = br ? 2'b01 : (j ? 2'b10 : 2'b00);
        end
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
        chk("flush_ifid", {31'b0, flush_ifid}, {31'b0, e_fl});
        chk("pc_sel", {30'b0, pc_sel}, {30'b0, e_sel});
        chk("pc_now", pc, m_pc);
        chk("redirect_pending", {31'b0, redirect_pending},
            {31'b0, m_pending});
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pending) begin
            if (rdy) begin
                m_pc      = br ? tgt : m_pend_pc;
                m_pending = 1'b0;
            end else if (br) begin
                m_pend_pc = tgt;
            end
        end else if (br || j) begin
            if (rdy) begin
                m_pc = tgt;
            end else begin
                m_pending = 1'b1;
                m_pend_pc = tgt;
            end
        end else if (!st && rdy) begin
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        chk("pc_next", pc, m_pc);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        imem_ready    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
        chk("rst_flush", {31'b0, flush_ifid}, 32'h0);
        chk("rst_sel", {30'b0, pc_sel}, 32'h0);
        chk("rst_rp", {31'b0, redirect_pending}, 32'h0);
        rst_n = 1'b1;

        // boot cycle then sequential 0,4,8
        idle(1'b1);
        chk("boot_pc0", pc, 32'h0);
        idle(1'b1);
        chk("seq_pc4", pc, 32'h4);
        idle(1'b1);
        chk("seq_pc8", pc, 32'h8);
        idle(1'b1);
        idle(1'b1);
        chk("seq_pc10", pc, 32'h10);

        // stall holds, branch during stall redirects
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("stall_hold", pc, 32'h10);
        step(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("stall_br", pc, 32'h80);

        // jump to 0x20 then branch to 0x100
        step(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b1);
        chk("jmp_20", pc, 32'h20);
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("br_100", pc, 32'h100);

        // branch beats jump in the same cycle
        step(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b1);
        chk("br_over_j", pc, 32'h200);

        // jump while imem busy for three cycles
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("pend_hold", pc, 32'h200);
        chk("pend_flag", {31'b0, redirect_pending}, 32'h1);
        idle(1'b1);
        chk("pend_apply", pc, 32'h40);

        // misaligned target and wraparound
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("align_top", pc, 32'hFFFF_FFFC);
        idle(1'b1);
        chk("wrap_zero", pc, 32'h0);
        idle(1'b1);

        // reset while a redirect is pending
        step(1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b0);
        chk("pre_rst_rp", {31'b0, redirect_pending}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_pc", pc, 32'h0);
        chk("async_rp", {31'b0, redirect_pending}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);
        chk("post_rst_seq", pc, 32'h4);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 7) == 0, $urandom,
                 ($urandom % 6) == 0, $urandom,
                 ($urandom % 5) == 0, ($urandom % 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
